// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing, five sample ticks per bit, one-byte holding
// register in front of the shift register so frames can run back-to-back.
module uart_tx #(
    parameter  int unsigned STOP_BITS = 1,
    localparam int unsigned DIV_W     = 10,
    localparam int unsigned BYTE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  over_sample_clk_cnt,
    input  logic [BYTE_W-1:0] tx_byte,
    input  logic              tx_byte_valid,
    output logic              tx_byte_ready,
    output logic              txd,
    output logic              tx_busy
);

    localparam int unsigned SUB_W = 3;
    localparam int unsigned IDX_W = 3;
    localparam logic [SUB_W-1:0] LAST_SUB  = SUB_W'(4);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(7);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [BYTE_W-1:0]   hold_byte_q, hold_byte_d;
    logic                hold_full_q, hold_full_d;
    logic                txd_q, txd_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic tick_c;
    logic bit_end_c;
    logic accept_c;
    logic frame_start_c;

    assign tick_c        = (tick_cnt_q == div_q);
    assign bit_end_c     = tick_c && (sub_cnt_q == LAST_SUB);
    assign accept_c      = tx_byte_valid && ready_q;
    assign frame_start_c = en && (state_d == START) && (state_q != START);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            tick_cnt_q  <= '0;
            sub_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_byte_q <= '0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_cnt_q  <= tick_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_byte_q <= hold_byte_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; disable abandons any frame in progress
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (hold_full_q) state_d = START;
                START: if (bit_end_c) state_d = DATA;
                DATA:  if (bit_end_c && (bit_idx_q == LAST_DATA)) state_d = STOP;
                STOP:  if (bit_end_c && (bit_idx_q == LAST_STOP)) begin
                           state_d = hold_full_q ? START : IDLE;
                       end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_comb begin
        div_d       = div_q;
        tick_cnt_d  = tick_cnt_q;
        sub_cnt_d   = sub_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_byte_d = hold_byte_q;
        hold_full_d = hold_full_q;

        if (!en) begin
            hold_full_d = 1'b0;
        end else begin
            if (frame_start_c) begin
                shift_d     = hold_byte_q;
                hold_full_d = 1'b0;
                div_d       = over_sample_clk_cnt;
                tick_cnt_d  = '0;
                sub_cnt_d   = '0;
                bit_idx_d   = '0;
            end else if (state_q != IDLE) begin
                if (tick_c) begin
                    tick_cnt_d = '0;
                    if (sub_cnt_q == LAST_SUB) begin
                        sub_cnt_d = '0;
                        if (state_q == DATA) begin
                            shift_d   = shift_q >> 1;
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                        end else if (state_q == STOP) begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        sub_cnt_d = sub_cnt_q + SUB_W'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + DIV_W'(1);
                end
            end
            // ready_q implies the holding register is empty, so this never races a load
            if (accept_c) begin
                hold_byte_d = tx_byte;
                hold_full_d = 1'b1;
            end
        end

        if (state_d == IDLE) begin
            tick_cnt_d = '0;
            sub_cnt_d  = '0;
            bit_idx_d  = '0;
        end

        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        ready_d = en && !hold_full_d;
        busy_d  = (state_d != IDLE) || hold_full_d;
    end

    assign txd           = txd_q;
    assign tx_byte_ready = ready_q;
    assign tx_busy       = busy_q;

endmodule
